// File: rtl/quadrant_prerotator.sv
// rtl/quadrant_prerotator.sv - CORDIC quadrant pre-rotation stage with skid-buffered valid/ready stream
// Optional feature: define QPR_SAT_EN to saturate negation of the most negative operand.
module quadrant_prerotator #(
    parameter int WIDTH   = 32,
    parameter int ANGLE_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x_in,
    input  logic [WIDTH-1:0]   y_in,
    input  logic [ANGLE_W-1:0] angle_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   x_out,
    output logic [WIDTH-1:0]   y_out,
    output logic [ANGLE_W-1:0] angle_out,
    output logic [1:0]         quad_out,
    output logic               sat_flag,
    input  logic               sat_clr,
    output logic [15:0]        sample_cnt
);

    localparam logic [WIDTH-1:0]   MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [ANGLE_W-1:0] QUARTER = {2'b01, {(ANGLE_W-2){1'b0}}};
    localparam int                 PW      = 2*WIDTH + ANGLE_W + 2;

    // The only overflow case of two's complement negation is the most negative value.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
`ifdef QPR_SAT_EN
        return (v == MIN_VAL) ? MAX_VAL : -v;
`else
        return -v;
`endif
    endfunction

    logic               in_xfer;
    logic               out_xfer;
    logic               skid_valid;
    logic [WIDTH-1:0]   n_x;
    logic [WIDTH-1:0]   n_y;
    logic [ANGLE_W-1:0] n_ang;
    logic [1:0]         n_quad;
    logic               n_sat;
    logic [PW-1:0]      new_pl;
    logic [PW-1:0]      out_pl;
    logic [PW-1:0]      skid_pl;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Region decode and pre-rotation of the incoming sample.
    always_comb begin
        n_x    = x_in;
        n_y    = y_in;
        n_ang  = angle_in;
        n_quad = 2'b00;
        n_sat  = 1'b0;
        if (!mode) begin
            n_ang = '0;
            if (x_in[WIDTH-1]) begin
                if (!y_in[WIDTH-1]) begin
                    n_x    = y_in;
                    n_y    = negate(x_in);
                    n_ang  = QUARTER;
                    n_quad = 2'b01;
                    n_sat  = (x_in == MIN_VAL);
                end else begin
                    n_x    = negate(y_in);
                    n_y    = x_in;
                    n_ang  = '0 - QUARTER;
                    n_quad = 2'b10;
                    n_sat  = (y_in == MIN_VAL);
                end
            end
        end else begin
            case (angle_in[ANGLE_W-1 -: 2])
                2'b01: begin
                    n_x    = negate(y_in);
                    n_y    = x_in;
                    n_ang  = angle_in - QUARTER;
                    n_quad = 2'b10;
                    n_sat  = (y_in == MIN_VAL);
                end
                2'b10: begin
                    n_x    = y_in;
                    n_y    = negate(x_in);
                    n_ang  = angle_in + QUARTER;
                    n_quad = 2'b01;
                    n_sat  = (x_in == MIN_VAL);
                end
                default: ;
            endcase
        end
    end

    assign new_pl = {n_x, n_y, n_ang, n_quad};
    assign {x_out, y_out, angle_out, quad_out} = out_pl;

    // Output register plus skid register; in_ready mirrors the skid being empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            out_pl     <= '0;
            skid_pl    <= '0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_pl     <= skid_pl;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
                in_ready   <= 1'b1;
            end else if (in_xfer) begin
                out_pl    <= new_pl;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_pl    <= new_pl;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_flag <= 1'b0;
        end else if (in_xfer && n_sat) begin
            sat_flag <= 1'b1;
        end else if (sat_clr) begin
            sat_flag <= 1'b0;
        end
    end

    // Count completed output transfers, wrapping naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt <= 16'd0;
        end else if (out_xfer) begin
            sample_cnt <= sample_cnt + 16'd1;
        end
    end

endmodule

// File: doc/quadrant_prerotator.md
QUADRANT_PREROTATOR -- requirements
Module: quadrant_prerotator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of x/y operands, two's complement.
REQ-002 SHALL have parameter ANGLE_W, default 32: angle width, two's complement, full scale 2^ANGLE_W = 360 deg, 90 deg = 2^(ANGLE_W-2).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 mode  input  1  0 = vectoring, 1 = rotation; sampled with each accepted input.
REQ-006 in_valid  input  1  input sample present.
REQ-007 in_ready  output  1  block can accept; registered.
REQ-008 x_in, y_in  input  WIDTH  operands.
REQ-009 angle_in  input  ANGLE_W  target angle (rotation mode); ignored in vectoring mode.
REQ-010 out_valid  output  1  output sample present.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 x_out, y_out  output  WIDTH  pre-rotated operands.
REQ-013 angle_out  output  ANGLE_W  correction angle (vectoring) or residual angle (rotation).
REQ-014 quad_out  output  2  region code: 00 pass, 01 rotated -90, 10 rotated +90.
REQ-015 sat_flag  output  1  sticky: any negation overflowed.
REQ-016 sat_clr  input  1  synchronous clear of sat_flag.
REQ-017 sample_cnt  output  16  count of output transfers, wraps modulo 2^16.

Function
REQ-018 Transfer in: in_valid && in_ready; transfer out: out_valid && out_ready.
REQ-019 Vectoring, x_in >= 0: pass through, angle_out = 0, quad 00.
REQ-020 Vectoring, x_in < 0, y_in >= 0: x_out = y_in, y_out = -x_in, angle_out = +90 deg, quad 01.
REQ-021 Vectoring, x_in < 0, y_in < 0: x_out = -y_in, y_out = x_in, angle_out = -90 deg, quad 10.
REQ-022 Rotation, angle_in top bits 00 or 11: pass through, angle_out = angle_in, quad 00.
REQ-023 Rotation, top bits 01: x_out = -y_in, y_out = x_in, angle_out = angle_in - 90 deg, quad 10.
REQ-024 Rotation, top bits 10: x_out = y_in, y_out = -x_in, angle_out = angle_in + 90 deg, quad 01.
REQ-025 Angle arithmetic SHALL wrap modulo 2^ANGLE_W.
REQ-026 Datapath: one output register plus one skid register; latency 1 cycle (accept at edge N, out_valid high after edge N).
REQ-027 in_ready SHALL equal NOT skid_valid, registered.
REQ-028 Output stalled while output register full and input accepted: sample goes to skid register; in_ready drops next cycle.
REQ-029 On output transfer with skid full: skid moves to output register, in_ready rises next cycle; order preserved, no loss, no duplication.
REQ-030 Simultaneous in and out transfer with skid empty: output register loads new sample, out_valid stays high.
REQ-031 Output fields SHALL hold stable while out_valid && !out_ready.
REQ-032 sample_cnt increments by 1 per output transfer; 0xFFFF wraps to 0x0000.
REQ-033 sat_flag sets when a negated operand equals -2^(WIDTH-1); sat_clr and set in same cycle: set wins.

Reset
REQ-034 rst high: out_valid=0, skid empty, in_ready=1 after release, x_out=y_out=angle_out=0, quad_out=00, sat_flag=0, sample_cnt=0.
REQ-035 Reset mid-operation SHALL discard both held samples without an output transfer.

Configuration
REQ-036 Macro QPR_SAT_EN defined: negation of -2^(WIDTH-1) yields 2^(WIDTH-1)-1 and sets sat_flag.
REQ-037 QPR_SAT_EN undefined: negation wraps two's complement (result -2^(WIDTH-1)); sat_flag still sets on that event.

Verification
REQ-038 WIDTH=32, mode 0, x=-100, y=50 -> x_out=50, y_out=100, angle_out=0x40000000, quad 01, 1 cycle later.
REQ-039 mode 0, x=-100, y=-50 -> x_out=50, y_out=-100, angle_out=0xC0000000, quad 10.
REQ-040 mode 1, x=1000, y=0, angle=0x60000000 (135 deg) -> x_out=0, y_out=1000, angle_out=0x20000000, quad 10.
REQ-041 mode 0, x=-1, y=0x80000000 -> with QPR_SAT_EN x_out=0x7FFFFFFF, without 0x80000000; sat_flag=1 both; sat_clr clears it.
REQ-042 Stream 5 samples, out_ready low 3 cycles -> in_ready low after 2 accepts, all 5 emerge in order, sample_cnt=5.
REQ-043 Assert rst with both registers full -> out_valid=0, sample_cnt unchanged at 0 after reset, no stale sample emitted.
